// File: rtl/solar_sensor_sampler.sv
// solar_sensor_sampler
// Sequences an external multiplexed 12-bit ADC through voltage (ch0),
// current (ch1) and temperature (ch2). It averages 2**AVG_LOG2 conversions
// per channel and presents registered voltage/current/temperature words
// together with a one-cycle per-frame strobe.
//
// Parameters:
//   DATA_W   - ADC sample and output word width
//   AVG_LOG2 - log2 of conversions averaged per channel (0 = no averaging)
//   SETTLE   - idle cycles after every adc_ch change before adc_start (>=1)
//   TIMEOUT  - max cycles waiting for adc_done after adc_start (>=1)
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   enable       in   1 = run frames continuously, 0 = stop after current frame
//   clear_err    in   one-cycle pulse, clears adc_timeout
//   adc_ch       out  ADC mux select: 0 voltage, 1 current, 2 temperature
//   adc_start    out  one-cycle conversion request
//   adc_done     in   one-cycle pulse, adc_data valid this cycle
//   adc_data     in   conversion result
//   voltage      out  averaged voltage, registered
//   current      out  averaged current, registered
//   temperature  out  averaged temperature, registered
//   sample_valid out  one-cycle pulse when the outputs update
//   frame_count  out  completed frames, wraps 255 -> 0
//   adc_timeout  out  sticky error flag
//
// Optional feature macro: SAMPLER_TEMP_DECIMATE_EN
//   When defined, the temperature channel is converted only on frames where
//   frame_count[1:0] == 0; on other frames ch2 is skipped and temperature
//   keeps its previous value.

module solar_sensor_sampler #(
  parameter int DATA_W   = 12,
  parameter int AVG_LOG2 = 2,
  parameter int SETTLE   = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear_err,
  output logic [1:0]        adc_ch,
  output logic              adc_start,
  input  logic              adc_done,
  input  logic [DATA_W-1:0] adc_data,
  output logic [DATA_W-1:0] voltage,
  output logic [DATA_W-1:0] current,
  output logic [DATA_W-1:0] temperature,
  output logic              sample_valid,
  output logic [7:0]        frame_count,
  output logic              adc_timeout
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int NCONV = 1 << AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int SET_W = $clog2(SETTLE + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_START,
    ST_WAIT,
    ST_ACCUM,
    ST_PUBLISH
  } state_t;

  state_t            state;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  conv_cnt;
  logic [SET_W-1:0]  settle_cnt;
  logic [TO_W-1:0]   timeout_cnt;
  logic [DATA_W-1:0] hold_v;
  logic [DATA_W-1:0] hold_i;
  logic [DATA_W-1:0] hold_t;
  logic              skip_temp;

`ifdef SAMPLER_TEMP_DECIMATE_EN
  assign skip_temp = (frame_count[1:0] != 2'd0);
`else
  assign skip_temp = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      adc_ch       <= 2'd0;
      adc_start    <= 1'b0;
      acc          <= '0;
      conv_cnt     <= '0;
      settle_cnt   <= '0;
      timeout_cnt  <= '0;
      hold_v       <= '0;
      hold_i       <= '0;
      hold_t       <= '0;
      voltage      <= '0;
      current      <= '0;
      temperature  <= '0;
      sample_valid <= 1'b0;
      frame_count  <= 8'd0;
      adc_timeout  <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      adc_start    <= 1'b0;
      // A timeout raised later in this block overrides a coincident clear.
      if (clear_err) begin
        adc_timeout <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (enable) begin
            adc_ch     <= 2'd0;
            settle_cnt <= '0;
            state      <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          // adc_start is raised on entry to START so it is high for
          // exactly the one cycle spent in that state.
          if (settle_cnt == SET_W'(SETTLE - 1)) begin
            adc_start <= 1'b1;
            state     <= ST_START;
          end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
          end
        end

        ST_START: begin
          // The request cycle itself is the first waited cycle.
          timeout_cnt <= TO_W'(1);
          state       <= ST_WAIT;
        end

        ST_WAIT: begin
          // adc_done is tested first so it wins over a coincident expiry.
          if (adc_done) begin
            acc      <= acc + ACC_W'(adc_data);
            conv_cnt <= conv_cnt + CNT_W'(1);
            state    <= ST_ACCUM;
          end else if (timeout_cnt >= TO_W'(TIMEOUT - 1)) begin
            adc_timeout <= 1'b1;
            acc         <= '0;
            conv_cnt    <= '0;
            adc_ch      <= 2'd0;
            state       <= ST_IDLE;
          end else begin
            timeout_cnt <= timeout_cnt + TO_W'(1);
          end
        end

        ST_ACCUM: begin
          if (conv_cnt != CNT_W'(NCONV)) begin
            adc_start <= 1'b1;
            state     <= ST_START;
          end else begin
            acc      <= '0;
            conv_cnt <= '0;
            // Dropping the low AVG_LOG2 bits is the truncating divide.
            case (adc_ch)
              2'd0:    hold_v <= acc[ACC_W-1:AVG_LOG2];
              2'd1:    hold_i <= acc[ACC_W-1:AVG_LOG2];
              default: hold_t <= acc[ACC_W-1:AVG_LOG2];
            endcase
            if (adc_ch == 2'd2 || (adc_ch == 2'd1 && skip_temp)) begin
              state <= ST_PUBLISH;
            end else begin
              adc_ch     <= adc_ch + 2'd1;
              settle_cnt <= '0;
              state      <= ST_SETTLE;
            end
          end
        end

        ST_PUBLISH: begin
          voltage      <= hold_v;
          current      <= hold_i;
          temperature  <= hold_t;
          sample_valid <= 1'b1;
          frame_count  <= frame_count + 8'd1;
          adc_ch       <= 2'd0;
          settle_cnt   <= '0;
          state        <= enable ? ST_SETTLE : ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
